// File: rtl/sopc_nios2_0_oci_pkg.sv
// Shared definitions for the Nios II OCI debug-RAM access scheduler:
// FSM state encoding, requester/grant encoding and JTAG data-out field positions.
package sopc_nios2_0_oci_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RESP    = 2'd3
    } oci_state_e;

    // Grant encoding; also the bit index of each requester in the arbiter request vector
    localparam logic GNT_CPU  = 1'b0;
    localparam logic GNT_JTAG = 1'b1;

    // Field positions inside the 38-bit JTAG data-out word
    localparam int JDO_RD_BIT    = 34;
    localparam int JDO_WDATA_LSB = 3;
    localparam int JDO_ADDR_LSB  = 17;

endpackage

// File: rtl/sopc_nios2_0_oci_rr_arb.sv
// Two-way round-robin arbiter for the OCI RAM scheduler.
// req[GNT_CPU] is the CPU request and req[GNT_JTAG] the JTAG request. When both
// request, the requester that was not granted last wins. Purely combinational.
module sopc_nios2_0_oci_rr_arb
    import sopc_nios2_0_oci_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt
);

    // Pick a winner from the request vector and the previous grant
    always_comb begin
        gnt_valid = 1'b0;
        gnt       = GNT_CPU;
        case (req)
            2'b01: begin
                gnt_valid = 1'b1;
                gnt       = GNT_CPU;
            end
            2'b10: begin
                gnt_valid = 1'b1;
                gnt       = GNT_JTAG;
            end
            2'b11: begin
                gnt_valid = 1'b1;
                gnt       = ~last_grant;
            end
            default: begin
                gnt_valid = 1'b0;
                gnt       = GNT_CPU;
            end
        endcase
    end

endmodule

// File: rtl/sopc_nios2_0_oci_access_sched.sv
// Nios II OCI debug-RAM access scheduler.
// Arbitrates the JTAG debug module (one-deep pending request) and the CPU
// Avalon-MM debug slave onto a single-port synchronous RAM, round-robin.
// Optional feature macro: OCI_ACCESS_WPROT_EN -- CPU writes at or above
// WPROT_BASE are suppressed at the RAM and flagged on wprot_hit.
module sopc_nios2_0_oci_access_sched
    import sopc_nios2_0_oci_pkg::*;
#(
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] WPROT_BASE = 8'hE0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              jtag_busy,
    output logic              jtag_overrun,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_en,
    output logic              ram_wren,
    output logic [31:0]       ram_wdata,
`ifdef OCI_ACCESS_WPROT_EN
    output logic              wprot_hit,
`endif
    input  logic [31:0]       ram_rdata
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    oci_state_e          state_r, state_s;
    logic                gnt_r;
    logic                req_write_r;
    logic                last_grant_r;
    logic [ADDR_W-1:0]   mon_a_reg_r;
    logic [31:0]         mon_d_reg_r;
    logic [31:0]         cpu_rdata_r;
    logic                waitreq_r;
    logic                pend_valid_r;
    logic                pend_write_r;
    logic [31:0]         pend_wdata_r;
    logic                overrun_r;
    logic                ram_en_r;
    logic                ram_wren_r;
    logic [ADDR_W-1:0]   ram_addr_r;
    logic [31:0]         ram_wdata_r;

    logic                cpu_req_s;
    logic                arb_valid_s;
    logic                arb_gnt_s;
    logic                issue_s;
    logic                waitreq_s;
    logic                sel_write_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [31:0]         sel_wdata_s;
    logic                wprot_s;
    logic                busy_s;
    logic                strobe_s;
    logic                accept_s;

    assign cpu_req_s = avs_read | avs_write;

    sopc_nios2_0_oci_rr_arb u_arb (
        .req        ({pend_valid_r, cpu_req_s}),
        .last_grant (last_grant_r),
        .gnt_valid  (arb_valid_s),
        .gnt        (arb_gnt_s)
    );

    // A JTAG transfer is outstanding while pending or while it owns a non-idle FSM
    assign busy_s   = pend_valid_r | ((gnt_r == GNT_JTAG) && (state_r != ST_IDLE));
    assign strobe_s = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign accept_s = strobe_s & ~busy_s;

`ifdef OCI_ACCESS_WPROT_EN
    logic wprot_hit_r;
    assign wprot_s   = (arb_gnt_s == GNT_CPU) && avs_write && (avs_address >= WPROT_BASE);
    assign wprot_hit = wprot_hit_r;

    // Single-cycle flag aligned with the suppressed ISSUE cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wprot_hit_r <= 1'b0;
        end else begin
            wprot_hit_r <= issue_s & wprot_s;
        end
    end
`else
    logic unused_wprot_s;
    assign wprot_s        = 1'b0;
    assign unused_wprot_s = ^WPROT_BASE;
`endif

    // Bits of jdo that carry no meaning for this block
    logic unused_jdo_s;
    assign unused_jdo_s = ^{jdo[37:35], jdo[2:0]};

    // Route the winning requester's access fields toward the RAM
    always_comb begin
        if (arb_gnt_s == GNT_JTAG) begin
            sel_write_s = pend_write_r;
            sel_addr_s  = mon_a_reg_r;
            sel_wdata_s = pend_wdata_r;
        end else begin
            sel_write_s = avs_write;
            sel_addr_s  = avs_address;
            sel_wdata_s = avs_writedata;
        end
    end

    // Next-state logic and the next value of the CPU completion handshake
    always_comb begin
        state_s   = state_r;
        issue_s   = 1'b0;
        waitreq_s = 1'b1;
        case (state_r)
            ST_IDLE: begin
                if (arb_valid_s) begin
                    state_s = ST_ISSUE;
                    issue_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (req_write_r) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: state_s = ST_RESP;
            ST_RESP:    state_s = ST_IDLE;
            default:    state_s = ST_IDLE;
        endcase
        // Write completes in ISSUE, read completes in RESP
        if (issue_s && (arb_gnt_s == GNT_CPU) && avs_write) begin
            waitreq_s = 1'b0;
        end else if ((state_r == ST_RD_WAIT) && (gnt_r == GNT_CPU)) begin
            waitreq_s = 1'b0;
        end else begin
            waitreq_s = 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Grant bookkeeping: current owner, its direction, and round-robin history
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            gnt_r        <= GNT_CPU;
            req_write_r  <= 1'b0;
            last_grant_r <= GNT_CPU;
        end else begin
            if (issue_s) begin
                gnt_r       <= arb_gnt_s;
                req_write_r <= sel_write_s;
            end else begin
                gnt_r       <= gnt_r;
                req_write_r <= req_write_r;
            end
            if (state_r == ST_ISSUE) begin
                last_grant_r <= gnt_r;
            end else begin
                last_grant_r <= last_grant_r;
            end
        end
    end

    // RAM port registers, loaded on the grant edge so they are valid during ISSUE
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ram_en_r    <= 1'b0;
            ram_wren_r  <= 1'b0;
            ram_addr_r  <= {ADDR_W{1'b0}};
            ram_wdata_r <= 32'd0;
        end else if (issue_s) begin
            ram_en_r    <= 1'b1;
            ram_wren_r  <= sel_write_s & ~wprot_s;
            ram_addr_r  <= sel_addr_s;
            ram_wdata_r <= sel_wdata_s;
        end else begin
            ram_en_r    <= 1'b0;
            ram_wren_r  <= 1'b0;
            ram_addr_r  <= ram_addr_r;
            ram_wdata_r <= ram_wdata_r;
        end
    end

    // JTAG pending request, monitor address and sticky overrun flag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_valid_r <= 1'b0;
            pend_write_r <= 1'b0;
            pend_wdata_r <= 32'd0;
            mon_a_reg_r  <= {ADDR_W{1'b0}};
            overrun_r    <= 1'b0;
        end else begin
            if (accept_s) begin
                if (take_action_ocimem_a) begin
                    mon_a_reg_r  <= jdo[JDO_ADDR_LSB+ADDR_W-1:JDO_ADDR_LSB];
                    pend_valid_r <= jdo[JDO_RD_BIT];
                    pend_write_r <= 1'b0;
                end else if (take_action_ocimem_b) begin
                    pend_valid_r <= 1'b1;
                    pend_write_r <= 1'b1;
                    pend_wdata_r <= jdo[JDO_WDATA_LSB+31:JDO_WDATA_LSB];
                end else begin
                    pend_valid_r <= 1'b1;
                    pend_write_r <= 1'b0;
                end
            end else if ((state_r == ST_ISSUE) && (gnt_r == GNT_JTAG) && req_write_r) begin
                pend_valid_r <= 1'b0;
                mon_a_reg_r  <= mon_a_reg_r + ADDR_ONE;
            end else if ((state_r == ST_RD_WAIT) && (gnt_r == GNT_JTAG)) begin
                pend_valid_r <= 1'b0;
                mon_a_reg_r  <= mon_a_reg_r + ADDR_ONE;
            end else begin
                pend_valid_r <= pend_valid_r;
                mon_a_reg_r  <= mon_a_reg_r;
            end
            if (strobe_s && busy_s) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    // Read-data capture and the registered CPU handshake
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mon_d_reg_r <= 32'd0;
            cpu_rdata_r <= 32'd0;
            waitreq_r   <= 1'b1;
        end else begin
            waitreq_r <= waitreq_s;
            if ((state_r == ST_RD_WAIT) && (gnt_r == GNT_JTAG)) begin
                mon_d_reg_r <= ram_rdata;
            end else if ((state_r == ST_RD_WAIT) && (gnt_r == GNT_CPU)) begin
                cpu_rdata_r <= ram_rdata;
            end else begin
                mon_d_reg_r <= mon_d_reg_r;
                cpu_rdata_r <= cpu_rdata_r;
            end
        end
    end

    assign avs_readdata    = cpu_rdata_r;
    assign avs_waitrequest = waitreq_r;
    assign MonDReg         = mon_d_reg_r;
    assign jtag_busy       = busy_s;
    assign jtag_overrun    = overrun_r;
    assign ram_addr        = ram_addr_r;
    assign ram_en          = ram_en_r;
    assign ram_wren        = ram_wren_r;
    assign ram_wdata       = ram_wdata_r;

endmodule

// File: tb/tb_sopc_nios2_0_oci_access_sched.sv
// Self-checking bench for sopc_nios2_0_oci_access_sched: directed steps followed
// by randomized transactions checked against a transaction-level memory model.
module tb_sopc_nios2_0_oci_access_sched;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = 38'd0;
    logic        take_action_ocimem_a = 1'b0;
    logic        take_action_ocimem_b = 1'b0;
    logic        take_no_action_ocimem_a = 1'b0;
    logic [7:0]  avs_address = 8'd0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = 32'd0;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [31:0] MonDReg;
    logic        jtag_busy;
    logic        jtag_overrun;
    logic [7:0]  ram_addr;
    logic        ram_en;
    logic        ram_wren;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'd0;
`ifdef OCI_ACCESS_WPROT_EN
    logic        wprot_hit;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sopc_nios2_0_oci_access_sched dut (
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_ocimem_a(take_action_ocimem_a),
        .take_action_ocimem_b(take_action_ocimem_b),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .avs_waitrequest(avs_waitrequest), .MonDReg(MonDReg),
        .jtag_busy(jtag_busy), .jtag_overrun(jtag_overrun),
        .ram_addr(ram_addr), .ram_en(ram_en), .ram_wren(ram_wren), .ram_wdata(ram_wdata),
`ifdef OCI_ACCESS_WPROT_EN
        .wprot_hit(wprot_hit),
`endif
        .ram_rdata(ram_rdata)
    );

    // Single-port synchronous RAM attached to the DUT, plus a write counter
    logic [31:0] tb_ram [0:255];
    int          ram_wr_cnt = 0;
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wren) begin
                tb_ram[ram_addr] <= ram_wdata;
                ram_wr_cnt <= ram_wr_cnt + 1;
            end
            ram_rdata <= tb_ram[ram_addr];
        end
    end

    // Reference model: memory contents and JTAG monitor address
    logic [31:0] ref_mem [0:255];
    logic [7:0]  ref_mona;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [37:0] jdo_addr(input logic rd, input logic [7:0] a);
        logic [37:0] v;
        v = 38'd0;
        v[34] = rd;
        v[24:17] = a;
        return v;
    endfunction

    function automatic logic [37:0] jdo_data(input logic [31:0] d);
        logic [37:0] v;
        v = 38'd0;
        v[34:3] = d;
        return v;
    endfunction

    function automatic bit cpu_write_lands(input logic [7:0] a);
`ifdef OCI_ACCESS_WPROT_EN
        return (a < 8'hE0);
`else
        return (a == a);
`endif
    endfunction

    // One JTAG strobe (0=ocimem_a, 1=ocimem_b, 2=no_action), then wait until idle
    task automatic jtag_op(input int kind, input logic [37:0] d, output int cyc);
        jdo = d;
        take_action_ocimem_a    = (kind == 0);
        take_action_ocimem_b    = (kind == 1);
        take_no_action_ocimem_a = (kind == 2);
        tick();
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        cyc = 0;
        while (jtag_busy && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    // One CPU transfer; cyc counts cycles until waitrequest drops
    task automatic cpu_xfer(input bit wr, input bit rd_also, input logic [7:0] a,
                            input logic [31:0] wd, output logic [31:0] rd, output int cyc);
        avs_address   = a;
        avs_writedata = wd;
        avs_write     = wr;
        avs_read      = !wr || rd_also;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (avs_waitrequest && cyc < 40);
        rd = avs_readdata;
        avs_read  = 1'b0;
        avs_write = 1'b0;
        tick();
    endtask

    initial begin
        int          cyc;
        int          wr_before;
        int          mism;
        logic [31:0] rdv;
        logic [31:0] d;
        logic [7:0]  a;
        for (int i = 0; i < 256; i++) begin
            d = $urandom;
            tb_ram[i]  = d;
            ref_mem[i] = d;
        end
        ref_mona = 8'd0;

        // 1. Reset held with a CPU read pending, then release
        avs_address = 8'h05;
        avs_read    = 1'b1;
        tick(); tick(); tick();
        chk("rst_waitreq", {31'd0, avs_waitrequest}, 32'd1);
        chk("rst_mondreg", MonDReg, 32'd0);
        chk("rst_readdata", avs_readdata, 32'd0);
        chk("rst_busy_ovr", {30'd0, jtag_busy, jtag_overrun}, 32'd0);
        chk("rst_ram_ctl", {30'd0, ram_en, ram_wren}, 32'd0);
        chk("rst_ram_addr", {24'd0, ram_addr}, 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
`ifdef OCI_ACCESS_WPROT_EN
        chk("rst_wprot", {31'd0, wprot_hit}, 32'd0);
`endif
        reset_n = 1'b1;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (avs_waitrequest && cyc < 40);
        chk("rst_cpu_lat", cyc, 32'd3);
        chk("rst_cpu_data", avs_readdata, ref_mem[8'h05]);
        avs_read = 1'b0;
        tick();

        // 2. JTAG address load, write, read back
        jtag_op(0, jdo_addr(1'b0, 8'h10), cyc);
        chk("j_seta_lat", cyc, 32'd0);
        jtag_op(1, jdo_data(32'hDEADBEEF), cyc);
        ref_mem[8'h10] = 32'hDEADBEEF;
        chk("j_wr_lat", cyc, 32'd2);
        chk("j_wr_ram", tb_ram[8'h10], 32'hDEADBEEF);
        chk("j_wr_mona", {24'd0, dut.mon_a_reg_r}, 32'h11);
        jdo = jdo_addr(1'b1, 8'h10);
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        tick();
        chk("j_rd_issue", {23'd0, ram_en, ram_wren, ram_addr}, {23'd0, 1'b1, 1'b0, 8'h10});
        tick();
        tick();
        chk("j_rd_data", MonDReg, 32'hDEADBEEF);
        cyc = 0;
        while (jtag_busy && cyc < 40) begin tick(); cyc++; end
        chk("j_rd_done", {31'd0, jtag_busy}, 32'd0);
        ref_mona = 8'h11;

        // 3. Contention: last grant CPU, JTAG read and next CPU read both pending in IDLE
        avs_address = 8'h40;
        avs_read    = 1'b1;
        tick();
        tick();
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
        chk("c_first_done", {31'd0, avs_waitrequest}, 32'd0);
        chk("c_first_data", avs_readdata, ref_mem[8'h40]);
        tick();
        avs_address = 8'h20;
        tick();
        chk("c_jtag_first", {23'd0, ram_en, ram_wren, ram_addr}, {23'd0, 1'b1, 1'b0, ref_mona});
        chk("c_cpu_waits", {31'd0, avs_waitrequest}, 32'd1);
        cyc = 0;
        do begin tick(); cyc++; end while (avs_waitrequest && cyc < 40);
        chk("c_cpu_lat", cyc, 32'd6);
        chk("c_cpu_data", avs_readdata, ref_mem[8'h20]);
        chk("c_jtag_data", MonDReg, ref_mem[ref_mona]);
        ref_mona = ref_mona + 8'd1;
        avs_read = 1'b0;
        tick();

        // 4. Overrun and MonAReg wrap
        jtag_op(0, jdo_addr(1'b0, 8'hFF), cyc);
        wr_before = ram_wr_cnt;
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
        jdo = jdo_data(32'h55AA55AA);
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        cyc = 0;
        while (jtag_busy && cyc < 40) begin tick(); cyc++; end
        chk("o_overrun", {31'd0, jtag_overrun}, 32'd1);
        chk("o_rd_data", MonDReg, ref_mem[8'hFF]);
        chk("o_wrap", {24'd0, dut.mon_a_reg_r}, 32'd0);
        chk("o_no_write", ram_wr_cnt, wr_before);
        ref_mona = 8'h00;

        // Randomized transactions against the model
        for (int n = 0; n < 60; n++) begin
            a = 8'($urandom_range(0, 255));
            d = $urandom;
            case ($urandom_range(0, 5))
                0: begin
                    jtag_op(0, jdo_addr(1'b0, a), cyc);
                    ref_mona = a;
                    chk("r_seta_lat", cyc, 32'd0);
                end
                1: begin
                    jtag_op(0, jdo_addr(1'b1, a), cyc);
                    chk("r_aread", MonDReg, ref_mem[a]);
                    chk("r_aread_lat", cyc, 32'd4);
                    ref_mona = a + 8'd1;
                end
                2: begin
                    jtag_op(1, jdo_data(d), cyc);
                    ref_mem[ref_mona] = d;
                    ref_mona = ref_mona + 8'd1;
                    chk("r_jwr_lat", cyc, 32'd2);
                end
                3: begin
                    jtag_op(2, 38'd0, cyc);
                    chk("r_nread", MonDReg, ref_mem[ref_mona]);
                    ref_mona = ref_mona + 8'd1;
                end
                4: begin
                    cpu_xfer(1'b0, 1'b0, a, d, rdv, cyc);
                    chk("r_crd", rdv, ref_mem[a]);
                    chk("r_crd_lat", cyc, 32'd3);
                end
                default: begin
                    cpu_xfer(1'b1, n[0], a, d, rdv, cyc);
                    if (cpu_write_lands(a)) ref_mem[a] = d;
                    chk("r_cwr_lat", cyc, 32'd1);
                end
            endcase
        end

`ifdef OCI_ACCESS_WPROT_EN
        // 5. Write protection of the upper window
        avs_address   = 8'hE4;
        avs_writedata = 32'h12345678;
        avs_write     = 1'b1;
        tick();
        chk("w_hit", {29'd0, wprot_hit, avs_waitrequest, ram_wren}, {29'd0, 1'b1, 1'b0, 1'b0});
        avs_write = 1'b0;
        tick();
        chk("w_pulse_end", {31'd0, wprot_hit}, 32'd0);
        chk("w_ram_kept", tb_ram[8'hE4], ref_mem[8'hE4]);
        cpu_xfer(1'b1, 1'b0, 8'hDF, 32'hCAFEF00D, rdv, cyc);
        ref_mem[8'hDF] = 32'hCAFEF00D;
        chk("w_below_ram", tb_ram[8'hDF], 32'hCAFEF00D);
`endif

        // 6. Reset during RD_WAIT of a JTAG read
        jdo = jdo_addr(1'b1, 8'h33);
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        tick();
        tick();
        wr_before = ram_wr_cnt;
        reset_n = 1'b0;
        tick();
        chk("x_mondreg", MonDReg, 32'd0);
        chk("x_busy_ovr", {30'd0, jtag_busy, jtag_overrun}, 32'd0);
        chk("x_mona", {24'd0, dut.mon_a_reg_r}, 32'd0);
        reset_n = 1'b1;
        tick(); tick(); tick();
        chk("x_idle_after", {30'd0, jtag_busy, avs_waitrequest}, 32'd1);
        chk("x_no_write", ram_wr_cnt, wr_before);

        mism = 0;
        for (int i = 0; i < 256; i++) begin
            if (tb_ram[i] !== ref_mem[i]) mism++;
        end
        chk("mem_final", mism, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
